// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage sitting directly in front of a combinational
// instruction memory. It owns the PC, captures each read into a 2-entry in-order fetch
// buffer, and presents {inst, pc, pc+4} to decode over a valid/ready handshake.
// Branch/jump redirects flush the buffer. A misaligned or out-of-range PC raises a
// sticky fault.
//
// Optional feature macro: HALT_ON_ZERO_EN. When it is defined, fetching an all-zero
// word stops fetch and raises a sticky halt. When it is undefined, zero words are pushed
// like any other word and halted is tied 0.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   imem_addr           word address to instruction memory (pc[ADDR_W+1:2])
//   imem_data           combinational read data for imem_addr
//   redirect_valid/pc   branch/jump redirect with new byte address
//   out_valid/ready     decode handshake for the head buffer entry
//   out_inst/pc/pc_plus4  head entry (NOP / 0 / 0 when empty)
//   fault               sticky misaligned / out-of-range PC flag
//   halted              sticky zero-word halt (0 unless HALT_ON_ZERO_EN)
module fetch_unit #(
  parameter int unsigned ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_pc_plus4,
  output logic              fault,
  output logic              halted
);

  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic [1:0] {StRun, StFault, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  // Entry 0 is always the head; entry 1 is only meaningful when count_q == 2.
  logic [31:0] head_inst_q, head_inst_d, head_pc_q, head_pc_d;
  logic [31:0] tail_inst_q, tail_inst_d, tail_pc_q, tail_pc_d;

  logic pc_ok, pop, fetch, zero_halt, push;

  assign imem_addr = pc_q[ADDR_W+1:2];
  // Everything above the fetchable window must be zero, so imem_addr never aliases.
  assign pc_ok     = (pc_q[1:0] == 2'b00) && ((pc_q >> (ADDR_W + 2)) == 32'h0);
  assign pop       = (count_q != 2'd0) && out_ready;
  assign fetch     = (state_q == StRun) && pc_ok && !redirect_valid &&
                     ((count_q != 2'd2) || pop);

  always_comb begin
    zero_halt = 1'b0;
`ifdef HALT_ON_ZERO_EN
    zero_halt = fetch && (imem_data == 32'h0);
`endif
    push = fetch && !zero_halt;
  end

  // Buffer next state. A redirect drops everything; a head transfer in that same cycle
  // is already complete on the decode side.
  always_comb begin
    count_d     = count_q;
    head_inst_d = head_inst_q;
    head_pc_d   = head_pc_q;
    tail_inst_d = tail_inst_q;
    tail_pc_d   = tail_pc_q;
    if (redirect_valid) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_inst_d = imem_data;
            head_pc_d   = pc_q;
          end else begin
            tail_inst_d = imem_data;
            tail_pc_d   = pc_q;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_inst_d = tail_inst_q;
          head_pc_d   = tail_pc_q;
          count_d     = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            head_inst_d = tail_inst_q;
            head_pc_d   = tail_pc_q;
            tail_inst_d = imem_data;
            tail_pc_d   = pc_q;
          end else begin
            head_inst_d = imem_data;
            head_pc_d   = pc_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Control FSM and PC.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_valid) begin
      state_d = StRun;
      pc_d    = redirect_pc;
    end else begin
      if (state_q == StRun) begin
        if (!pc_ok) begin
          state_d = StFault;
        end else if (zero_halt) begin
          state_d = StHalt;
        end
      end
      if (push) begin
        pc_d = pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      count_q <= 2'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  // Payload registers need no reset; count_q qualifies them.
  always_ff @(posedge clk) begin
    head_inst_q <= head_inst_d;
    head_pc_q   <= head_pc_d;
    tail_inst_q <= tail_inst_d;
    tail_pc_q   <= tail_pc_d;
  end

  assign out_valid    = (count_q != 2'd0);
  assign out_inst     = out_valid ? head_inst_q : Nop;
  assign out_pc       = out_valid ? head_pc_q : 32'h0;
  assign out_pc_plus4 = out_valid ? (head_pc_q + 32'd4) : 32'h0;
  assign fault        = (state_q == StFault);

`ifdef HALT_ON_ZERO_EN
  assign halted = (state_q == StHalt);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit. A queue-based reference model of the fetch buffer is
// checked against every output on every cycle. Directed scenarios are followed by a
// randomized phase that mixes redirects, resets and back-pressure.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_ready = 1'b0;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic        out_valid;
  logic [31:0] out_inst, out_pc, out_pc_plus4;
  logic        fault, halted;

  logic [31:0] mem [64];
  assign imem_data = mem[imem_addr];

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(6), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4),
    .fault          (fault),
    .halted         (halted)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: the buffer is a pair of queues, and the PC and sticky flags are
  // plain variables.
  logic [31:0] q_inst[$];
  logic [31:0] q_pc[$];
  logic [31:0] m_pc = 32'h0;
  bit          m_fault = 1'b0;
  bit          m_halt = 1'b0;
  bit          chk_en = 1'b0;
  logic [31:0] delivered_pc[$];
  logic [31:0] delivered_inst[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_model();
    bit v;
    v = (q_pc.size() != 0);
    chk("imem_addr", 32'(imem_addr), (m_pc >> 2) & 32'h3f);
    chk("out_valid", 32'(out_valid), 32'(v));
    chk("out_inst", out_inst, v ? q_inst[0] : 32'h0000_0013);
    chk("out_pc", out_pc, v ? q_pc[0] : 32'h0);
    chk("out_pc_plus4", out_pc_plus4, v ? q_pc[0] + 32'd4 : 32'h0);
    chk("fault", 32'(fault), 32'(m_fault));
    chk("halted", 32'(halted), 32'(m_halt));
  endtask

  task automatic step(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy);
    logic [31:0] w;
    bit          stop;
    bit          popped;
    popped = 1'b0;
    if (!r && q_pc.size() != 0 && rdy) begin
      delivered_pc.push_back(q_pc[0]);
      delivered_inst.push_back(q_inst[0]);
      popped = 1'b1;
    end
    if (r) begin
      q_pc.delete(); q_inst.delete();
      m_pc = 32'h0; m_fault = 1'b0; m_halt = 1'b0;
    end else if (rv) begin
      q_pc.delete(); q_inst.delete();
      m_pc = rpc; m_fault = 1'b0; m_halt = 1'b0;
    end else begin
      if (popped) begin
        void'(q_pc.pop_front());
        void'(q_inst.pop_front());
      end
      if (!m_fault && !m_halt) begin
        if ((m_pc % 4) != 0 || m_pc >= 32'd256) begin
          m_fault = 1'b1;
        end else if (q_pc.size() < 2) begin
          w    = mem[m_pc[7:2]];
          stop = 1'b0;
`ifdef HALT_ON_ZERO_EN
          stop = (w == 32'h0);
`endif
          if (stop) begin
            m_halt = 1'b1;
          end else begin
            q_pc.push_back(m_pc);
            q_inst.push_back(w);
            m_pc = m_pc + 32'd4;
          end
        end
      end
    end
  endtask

  // One clock: check the current state, drive inputs, advance the model, pass the edge.
  task automatic cyc(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy);
    @(negedge clk);
    if (chk_en) compare_model();
    rst = r; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    step(r, rv, rpc, rdy);
    if (r) chk_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit          saw_34;
    logic [31:0] inst_34;
    logic [31:0] rpc;
    int          sel;

    mem[0] = 32'h0000_2083;
    mem[1] = 32'h0040_2103;
    for (int i = 2; i < 64; i++) mem[i] = $urandom() | 32'h1;
    mem[13] = 32'h0;

    // Reset, then straight-line fetch with decode always ready.
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    chk("tp1_imem_addr", 32'(imem_addr), 32'h0);
    chk("tp1_empty", 32'(out_valid), 32'h0);
    cyc(0, 0, 0, 1);
    chk("tp1_valid", 32'(out_valid), 32'h1);
    chk("tp1_inst0", out_inst, 32'h0000_2083);
    chk("tp1_pc0", out_pc, 32'h0);
    chk("tp1_pc4", out_pc_plus4, 32'h4);
    cyc(0, 0, 0, 1);
    chk("tp1_inst1", out_inst, 32'h0040_2103);
    chk("tp1_pc1", out_pc, 32'h4);

    // Back-pressure saturates the buffer; releasing it drains in order without gaps.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
    chk("tp2_imem_addr_held", 32'(imem_addr), 32'h2);
    chk("tp2_head_pc", out_pc, 32'h0);
    delivered_pc.delete(); delivered_inst.delete();
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) chk("tp2_order", delivered_pc[i], 32'(4 * i));

    // Redirect with a head transfer in the same cycle.
    cyc(0, 1, 32'h14, 1);
    chk("tp3_flush", 32'(out_valid), 32'h0);
    cyc(0, 0, 0, 1);
    chk("tp3_pc", out_pc, 32'h14);
    chk("tp3_inst", out_inst, mem[5]);

    // Misaligned redirect faults; an aligned redirect recovers.
    cyc(0, 1, 32'h16, 1);
    chk("tp4_not_yet", 32'(fault), 32'h0);
    cyc(0, 0, 0, 1);
    chk("tp4_fault", 32'(fault), 32'h1);
    chk("tp4_empty", 32'(out_valid), 32'h0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("tp4_sticky", 32'(fault), 32'h1);
    cyc(0, 1, 32'h0, 1);
    chk("tp4_clear", 32'(fault), 32'h0);
    cyc(0, 0, 0, 1);
    chk("tp4_valid", 32'(out_valid), 32'h1);
    chk("tp4_pc", out_pc, 32'h0);

    // Reset while the buffer is full.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("tp6_valid", 32'(out_valid), 32'h0);
    chk("tp6_imem_addr", 32'(imem_addr), 32'h0);
    chk("tp6_fault", 32'(fault), 32'h0);
    chk("tp6_halted", 32'(halted), 32'h0);

    // Run off the end of the program and then the end of fetchable space.
    delivered_pc.delete(); delivered_inst.delete();
    for (int i = 0; i < 80; i++) cyc(0, 0, 0, 1);
    saw_34  = 1'b0;
    inst_34 = 32'hffff_ffff;
    foreach (delivered_pc[i]) begin
      if (delivered_pc[i] == 32'h34) begin
        saw_34  = 1'b1;
        inst_34 = delivered_inst[i];
      end
    end
`ifdef HALT_ON_ZERO_EN
    chk("tp5_halted", 32'(halted), 32'h1);
    chk("tp5_no_34", 32'(saw_34), 32'h0);
`else
    chk("tp5_saw_34", 32'(saw_34), 32'h1);
    chk("tp5_inst_34", inst_34, 32'h0);
    chk("tp5_fault", 32'(fault), 32'h1);
    chk("tp5_halted", 32'(halted), 32'h0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 64; i++) mem[i] = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom();
    cyc(1, 0, 0, 1);
    for (int i = 0; i < 600; i++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 70)      rpc = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      else if (sel < 85) rpc = 32'($urandom_range(0, 255));
      else               rpc = $urandom();
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0, rpc,
          $urandom_range(0, 3) != 0);
    end
    cyc(0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
